// File: rtl/tetris_pkg.sv
// tetris_pkg
// Shared definitions for the playfield blocks: board dimensions, the colour
// type with its "empty" code, and the state encoding of the static board
// writer's commit/clear sequencer.
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;

    typedef logic [2:0] color_t;

    localparam color_t COLOR_EMPTY = 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SCAN,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/row_full_check.sv
// row_full_check
// Reports whether one playfield row is completely occupied.
// Ports:
//   occupied : one non-empty flag per column of the row
//   full     : high when every flag is set
module row_full_check #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] occupied,
    output logic             full
);

    assign full = &occupied;

endmodule

// File: rtl/static_board_writer.sv
// static_board_writer
// Owns the registered static playfield. A landed piece is committed one cell
// per cycle, then rows are scanned bottom-up and every full row is removed by
// shifting everything above it down one row at a time. Line counts and the
// sticky top-out flag are updated when the sequence finishes.
// Ports:
//   Clk, Reset                      : clock, synchronous active-high reset
//   En_New_Static                   : one-cycle commit request
//   New_Static_Row/Column/Color     : four cell coordinates and their colour
//   Draw_Row/Column -> Draw_Color   : combinational VGA read port
//   Probe_Row/Column -> Probe_Occupied : combinational collision read port
//   Busy, Done                      : sequence in progress / end pulse
//   Lines_Cleared, Lines_Total      : rows cleared by last commit / running total
//   Top_Out                         : sticky game-over flag
module static_board_writer
    import tetris_pkg::*;
#(
    parameter int ROWS = BOARD_ROWS,
    parameter int COLS = BOARD_COLS
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            En_New_Static,
    input  logic [3:0][4:0] New_Static_Row,
    input  logic [3:0][3:0] New_Static_Column,
    input  logic [2:0]      New_Static_Color,
    input  logic [4:0]      Draw_Row,
    input  logic [3:0]      Draw_Column,
    output logic [2:0]      Draw_Color,
    input  logic [4:0]      Probe_Row,
    input  logic [3:0]      Probe_Column,
    output logic            Probe_Occupied,
    output logic            Busy,
    output logic            Done,
    output logic [2:0]      Lines_Cleared,
    output logic [9:0]      Lines_Total,
    output logic            Top_Out
);

    // Limits are widened by one bit so ROWS/COLS equal to a power of two
    // still compare correctly against the 5/4-bit coordinates.
    localparam logic [5:0] ROW_LIMIT = 6'(ROWS);
    localparam logic [4:0] COL_LIMIT = 5'(COLS);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);

    color_t          board [ROWS][COLS];
    state_t          state;
    logic [1:0]      wr_idx;
    logic [4:0]      scan_r;
    logic [4:0]      shift_k;
    logic [2:0]      clear_cnt;
    logic [3:0][4:0] lat_row;
    logic [3:0][3:0] lat_col;
    color_t          lat_color;

    logic [COLS-1:0] scan_flags;
    logic [COLS-1:0] row0_flags;
    logic            scan_full;
    logic            write_in_range;
    logic            draw_in_range;
    logic            probe_in_range;
    logic [10:0]     total_sum;
    logic [9:0]      total_next;

    // Occupancy flags for the row under the scan pointer (feeds the full-row
    // detector) and for the top row (feeds the top-out decision).
    always_comb begin
        scan_flags = '0;
        row0_flags = '0;
        for (int c = 0; c < COLS; c++) begin
            scan_flags[c] = (board[scan_r][c] != COLOR_EMPTY);
            row0_flags[c] = (board[0][c] != COLOR_EMPTY);
        end
    end

    row_full_check #(
        .WIDTH(COLS)
    ) u_scan_full (
        .occupied(scan_flags),
        .full    (scan_full)
    );

    assign write_in_range = ({1'b0, lat_row[wr_idx]} < ROW_LIMIT) &&
                            ({1'b0, lat_col[wr_idx]} < COL_LIMIT);

    // The running total saturates rather than wrapping.
    assign total_sum  = {1'b0, Lines_Total} + {8'd0, clear_cnt};
    assign total_next = total_sum[10] ? 10'h3FF : total_sum[9:0];

    // Read ports: outside the board the VGA sees empty while the collision
    // probe sees solid, so walls and floor stop falling pieces.
    assign draw_in_range  = ({1'b0, Draw_Row} < ROW_LIMIT) &&
                            ({1'b0, Draw_Column} < COL_LIMIT);
    assign probe_in_range = ({1'b0, Probe_Row} < ROW_LIMIT) &&
                            ({1'b0, Probe_Column} < COL_LIMIT);
    assign Draw_Color     = draw_in_range ? board[Draw_Row][Draw_Column] : COLOR_EMPTY;
    assign Probe_Occupied = probe_in_range ? (board[Probe_Row][Probe_Column] != COLOR_EMPTY)
                                           : 1'b1;

    // Sequencer plus playfield storage. After a full row is removed the scan
    // pointer stays put, because the row that dropped into that slot has not
    // been looked at yet. Status outputs are updated on the edge that enters
    // DONE so they are already valid while Done is high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            wr_idx        <= '0;
            scan_r        <= '0;
            shift_k       <= '0;
            clear_cnt     <= '0;
            lat_row       <= '0;
            lat_col       <= '0;
            lat_color     <= COLOR_EMPTY;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Lines_Cleared <= '0;
            Lines_Total   <= '0;
            Top_Out       <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    board[r][c] <= COLOR_EMPTY;
                end
            end
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (En_New_Static && (New_Static_Color != COLOR_EMPTY)) begin
                        lat_row   <= New_Static_Row;
                        lat_col   <= New_Static_Column;
                        lat_color <= New_Static_Color;
                        wr_idx    <= '0;
                        clear_cnt <= '0;
                        Busy      <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (write_in_range) begin
                        board[lat_row[wr_idx]][lat_col[wr_idx]] <= lat_color;
                    end
                    wr_idx <= wr_idx + 2'd1;
                    if (wr_idx == 2'd3) begin
                        scan_r <= LAST_ROW;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_full) begin
                        clear_cnt <= clear_cnt + 3'd1;
                        shift_k   <= scan_r;
                        state     <= SHIFT;
                    end else if (scan_r == 5'd0) begin
                        Done          <= 1'b1;
                        Lines_Cleared <= clear_cnt;
                        Lines_Total   <= total_next;
                        if (|row0_flags) begin
                            Top_Out <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        scan_r <= scan_r - 5'd1;
                    end
                end
                SHIFT: begin
                    if (shift_k == 5'd0) begin
                        for (int c = 0; c < COLS; c++) begin
                            board[0][c] <= COLOR_EMPTY;
                        end
                        state <= SCAN;
                    end else begin
                        for (int c = 0; c < COLS; c++) begin
                            board[shift_k][c] <= board[shift_k - 5'd1][c];
                        end
                        shift_k <= shift_k - 5'd1;
                    end
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_static_board_writer.sv
// tb_static_board_writer
// Drives directed and randomized landed-piece commits into static_board_writer
// and compares timing, line counts, top-out and the full board image against a
// reference model that removes full rows by compaction.
module tb_static_board_writer;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    logic            Clk;
    logic            Reset;
    logic            En_New_Static;
    logic [3:0][4:0] New_Static_Row;
    logic [3:0][3:0] New_Static_Column;
    logic [2:0]      New_Static_Color;
    logic [4:0]      Draw_Row;
    logic [3:0]      Draw_Column;
    logic [2:0]      Draw_Color;
    logic [4:0]      Probe_Row;
    logic [3:0]      Probe_Column;
    logic            Probe_Occupied;
    logic            Busy;
    logic            Done;
    logic [2:0]      Lines_Cleared;
    logic [9:0]      Lines_Total;
    logic            Top_Out;

    int n_checks = 0;
    int n_fail   = 0;

    int              model [ROWS][COLS];
    int              m_total;
    bit              m_top;
    int              m_lines;
    logic [3:0][4:0] pc_rows;
    logic [3:0][3:0] pc_cols;

    static_board_writer dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .En_New_Static    (En_New_Static),
        .New_Static_Row   (New_Static_Row),
        .New_Static_Column(New_Static_Column),
        .New_Static_Color (New_Static_Color),
        .Draw_Row         (Draw_Row),
        .Draw_Column      (Draw_Column),
        .Draw_Color       (Draw_Color),
        .Probe_Row        (Probe_Row),
        .Probe_Column     (Probe_Column),
        .Probe_Occupied   (Probe_Occupied),
        .Busy             (Busy),
        .Done             (Done),
        .Lines_Cleared    (Lines_Cleared),
        .Lines_Total      (Lines_Total),
        .Top_Out          (Top_Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case the design wedges somewhere no bounded wait covers.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time exhausted");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_cell(input int i, input int r, input int c);
        pc_rows[i] = 5'(r);
        pc_cols[i] = 4'(c);
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = 0;
        m_total = 0;
        m_top   = 0;
        m_lines = 0;
    endtask

    // Writes the piece, finds all full rows, and removes them by keeping the
    // non-full rows in order at the bottom. A full row at original index f is
    // reached by the scan at f plus the number of rows already removed below
    // it, and costs that many plus one shift cycles and one rescan cycle.
    task automatic model_commit(input logic [2:0] color, output int exp_cycle);
        bit full_row [ROWS];
        int tmp [ROWS][COLS];
        int dst;
        int below;
        for (int i = 0; i < 4; i++)
            if (int'(pc_rows[i]) < ROWS && int'(pc_cols[i]) < COLS)
                model[pc_rows[i]][pc_cols[i]] = int'(color);
        for (int r = 0; r < ROWS; r++) begin
            full_row[r] = 1'b1;
            for (int c = 0; c < COLS; c++)
                if (model[r][c] == 0) full_row[r] = 1'b0;
        end
        exp_cycle = 4 + ROWS + 1;
        below = 0;
        for (int r = ROWS - 1; r >= 0; r--)
            if (full_row[r]) begin
                exp_cycle += r + below + 2;
                below++;
            end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                tmp[r][c] = 0;
        dst = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--)
            if (!full_row[r]) begin
                for (int c = 0; c < COLS; c++) tmp[dst][c] = model[r][c];
                dst--;
            end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = tmp[r][c];
        m_lines = below;
        m_total = (m_total + below > 1023) ? 1023 : m_total + below;
        for (int c = 0; c < COLS; c++)
            if (model[0][c] != 0) m_top = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    // Issues one commit with pc_rows/pc_cols and waits (bounded) for Done.
    // done_cycle counts cycles after the sampling edge; -1 means it never came.
    task automatic send_commit(input logic [2:0] color, output int done_cycle,
                               output int busy_low, output logic busy_after,
                               output logic done_after);
        @(negedge Clk);
        En_New_Static     = 1'b1;
        New_Static_Row    = pc_rows;
        New_Static_Column = pc_cols;
        New_Static_Color  = color;
        @(negedge Clk);
        En_New_Static = 1'b0;
        done_cycle = -1;
        busy_low   = 0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (Busy !== 1'b1) busy_low++;
            if (Done === 1'b1) begin
                done_cycle = cyc;
                break;
            end
            @(negedge Clk);
        end
        @(negedge Clk);
        busy_after = Busy;
        done_after = Done;
    endtask

    // Walks every cell through both read ports and counts disagreements with
    // the model; only call while the DUT is idle.
    task automatic read_board(output int diffs, output string first);
        diffs = 0;
        first = "none";
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                Draw_Row = 5'(r); Draw_Column = 4'(c);
                Probe_Row = 5'(r); Probe_Column = 4'(c);
                #1;
                if (Draw_Color !== 3'(model[r][c]) || Probe_Occupied !== (model[r][c] != 0)) begin
                    if (diffs == 0)
                        first = $sformatf("(%0d,%0d) color %0d occ %0b, model %0d", r, c,
                                          Draw_Color, Probe_Occupied, model[r][c]);
                    diffs++;
                end
            end
    endtask

    task automatic read_cell(input int r, input int c);
        Draw_Row = 5'(r); Draw_Column = 4'(c);
        Probe_Row = 5'(r); Probe_Column = 4'(c);
        #1;
    endtask

    task automatic test_reset();
        int diffs; string first;
        do_reset();
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %0b expected 0", Done); end
        n_checks++; if (Top_Out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_top_out: got %0b expected 0", Top_Out); end
        n_checks++; if (Lines_Cleared !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_lines_cleared: got %0d expected 0", Lines_Cleared); end
        n_checks++; if (Lines_Total !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_lines_total: got %0d expected 0", Lines_Total); end
        read_board(diffs, first);
        n_checks++; if (diffs !== 0) begin n_fail++; $display("[TB] FAIL reset_board: %0d bad cells, first %s, expected all empty", diffs, first); end
    endtask

    task automatic test_basic_commit();
        int exp, done_cyc, busy_low, diffs; logic b_after, d_after; string first;
        do_reset();
        set_cell(0, 19, 0); set_cell(1, 19, 1); set_cell(2, 18, 0); set_cell(3, 18, 1);
        model_commit(3'd3, exp);
        send_commit(3'd3, done_cyc, busy_low, b_after, d_after);
        n_checks++; if (done_cyc !== 25) begin n_fail++; $display("[TB] FAIL basic_done_cycle: got %0d expected 25", done_cyc); end
        n_checks++; if (busy_low !== 0) begin n_fail++; $display("[TB] FAIL basic_busy_high: %0d low cycles, expected 0", busy_low); end
        n_checks++; if (b_after !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_idle: got %0b expected 0", b_after); end
        n_checks++; if (d_after !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_done_pulse: got %0b expected 0", d_after); end
        n_checks++; if (Lines_Cleared !== 3'd0) begin n_fail++; $display("[TB] FAIL basic_lines: got %0d expected 0", Lines_Cleared); end
        for (int i = 0; i < 4; i++) begin
            read_cell(int'(pc_rows[i]), int'(pc_cols[i]));
            n_checks++; if (Draw_Color !== 3'd3) begin n_fail++; $display("[TB] FAIL basic_cell%0d: got %0d expected 3", i, Draw_Color); end
        end
        read_board(diffs, first);
        n_checks++; if (diffs !== 0) begin n_fail++; $display("[TB] FAIL basic_board: %0d bad cells, first %s", diffs, first); end
    endtask

    task automatic test_single_clear();
        int exp, done_cyc, busy_low, diffs; logic b_after, d_after; string first;
        do_reset();
        set_cell(0, 19, 0); set_cell(1, 19, 1); set_cell(2, 19, 2); set_cell(3, 19, 3);
        model_commit(3'd2, exp);
        send_commit(3'd2, done_cyc, busy_low, b_after, d_after);
        set_cell(0, 19, 4); set_cell(1, 19, 5); set_cell(2, 19, 9); set_cell(3, 19, 9);
        model_commit(3'd4, exp);
        send_commit(3'd4, done_cyc, busy_low, b_after, d_after);
        n_checks++; if (Lines_Cleared !== 3'd0) begin n_fail++; $display("[TB] FAIL single_preload_lines: got %0d expected 0", Lines_Cleared); end
        set_cell(0, 19, 6); set_cell(1, 19, 7); set_cell(2, 19, 8); set_cell(3, 18, 8);
        model_commit(3'd5, exp);
        send_commit(3'd5, done_cyc, busy_low, b_after, d_after);
        n_checks++; if (done_cyc !== 46) begin n_fail++; $display("[TB] FAIL single_done_cycle: got %0d expected 46", done_cyc); end
        n_checks++; if (Lines_Cleared !== 3'd1) begin n_fail++; $display("[TB] FAIL single_lines: got %0d expected 1", Lines_Cleared); end
        n_checks++; if (Lines_Total !== 10'd1) begin n_fail++; $display("[TB] FAIL single_total: got %0d expected 1", Lines_Total); end
        read_cell(19, 8);
        n_checks++; if (Draw_Color !== 3'd5) begin n_fail++; $display("[TB] FAIL single_dropped_cell: got %0d expected 5", Draw_Color); end
        read_board(diffs, first);
        n_checks++; if (diffs !== 0) begin n_fail++; $display("[TB] FAIL single_board: %0d bad cells, first %s", diffs, first); end
    endtask

    task automatic test_quad_clear();
        int exp, done_cyc, busy_low, diffs, idx; logic b_after, d_after; string first;
        do_reset();
        idx = 0;
        for (int r = 16; r < 20; r++)
            for (int c = 0; c < COLS; c++)
                if (c != 4) begin
                    set_cell(idx % 4, r, c);
                    idx++;
                    if (idx % 4 == 0) begin
                        model_commit(3'(1 + (idx / 4) % 7), exp);
                        send_commit(3'(1 + (idx / 4) % 7), done_cyc, busy_low, b_after, d_after);
                    end
                end
        n_checks++; if (done_cyc !== exp) begin n_fail++; $display("[TB] FAIL quad_preload_cycle: got %0d expected %0d", done_cyc, exp); end
        set_cell(0, 16, 4); set_cell(1, 17, 4); set_cell(2, 18, 4); set_cell(3, 19, 4);
        model_commit(3'd6, exp);
        send_commit(3'd6, done_cyc, busy_low, b_after, d_after);
        n_checks++; if (done_cyc !== exp) begin n_fail++; $display("[TB] FAIL quad_done_cycle: got %0d expected %0d", done_cyc, exp); end
        n_checks++; if (Lines_Cleared !== 3'd4) begin n_fail++; $display("[TB] FAIL quad_lines: got %0d expected 4", Lines_Cleared); end
        n_checks++; if (Lines_Total !== 10'd4) begin n_fail++; $display("[TB] FAIL quad_total: got %0d expected 4", Lines_Total); end
        read_board(diffs, first);
        n_checks++; if (diffs !== 0) begin n_fail++; $display("[TB] FAIL quad_board: %0d bad cells, first %s", diffs, first); end
    endtask

    task automatic test_ignored_requests();
        int exp, done_cyc, diffs, busy_seen; string first;
        do_reset();
        set_cell(0, 10, 0); set_cell(1, 10, 1); set_cell(2, 10, 2); set_cell(3, 10, 3);
        model_commit(3'd3, exp);
        @(negedge Clk);
        En_New_Static = 1'b1; New_Static_Row = pc_rows; New_Static_Column = pc_cols; New_Static_Color = 3'd3;
        @(negedge Clk);
        En_New_Static = 1'b0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (cyc == 10) begin
                En_New_Static = 1'b1;
                New_Static_Row = {5'd12, 5'd12, 5'd12, 5'd12};
                New_Static_Column = {4'd3, 4'd2, 4'd1, 4'd0};
                New_Static_Color = 3'd2;
            end else begin
                En_New_Static = 1'b0;
            end
            if (Done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(negedge Clk);
        end
        En_New_Static = 1'b0;
        @(negedge Clk);
        n_checks++; if (done_cyc !== exp) begin n_fail++; $display("[TB] FAIL busy_drop_cycle: got %0d expected %0d", done_cyc, exp); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_drop_idle: got %0b expected 0", Busy); end
        read_board(diffs, first);
        n_checks++; if (diffs !== 0) begin n_fail++; $display("[TB] FAIL busy_drop_board: %0d bad cells, first %s", diffs, first); end
        @(negedge Clk);
        En_New_Static = 1'b1;
        New_Static_Row = {5'd3, 5'd3, 5'd3, 5'd3};
        New_Static_Column = {4'd6, 4'd5, 4'd4, 4'd3};
        New_Static_Color = 3'd0;
        @(negedge Clk);
        En_New_Static = 1'b0;
        busy_seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (Busy !== 1'b0) busy_seen++;
            @(negedge Clk);
        end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("[TB] FAIL color0_busy: %0d busy cycles, expected 0", busy_seen); end
        read_board(diffs, first);
        n_checks++; if (diffs !== 0) begin n_fail++; $display("[TB] FAIL color0_board: %0d bad cells, first %s", diffs, first); end
    endtask

    task automatic test_top_out();
        int exp, done_cyc, busy_low; logic b_after, d_after;
        do_reset();
        set_cell(0, 0, 0); set_cell(1, 0, 1); set_cell(2, 1, 0); set_cell(3, 1, 1);
        model_commit(3'd7, exp);
        send_commit(3'd7, done_cyc, busy_low, b_after, d_after);
        n_checks++; if (Top_Out !== 1'b1) begin n_fail++; $display("[TB] FAIL top_out_set: got %0b expected 1", Top_Out); end
        set_cell(0, 19, 0); set_cell(1, 19, 1); set_cell(2, 19, 2); set_cell(3, 19, 3);
        model_commit(3'd1, exp);
        send_commit(3'd1, done_cyc, busy_low, b_after, d_after);
        n_checks++; if (done_cyc !== exp) begin n_fail++; $display("[TB] FAIL top_out_next_cycle: got %0d expected %0d", done_cyc, exp); end
        n_checks++; if (Top_Out !== 1'b1) begin n_fail++; $display("[TB] FAIL top_out_sticky: got %0b expected 1", Top_Out); end
        do_reset();
        n_checks++; if (Top_Out !== 1'b0) begin n_fail++; $display("[TB] FAIL top_out_reset: got %0b expected 0", Top_Out); end
    endtask

    task automatic test_probe_bounds();
        int exp, done_cyc, busy_low, diffs; logic b_after, d_after; string first;
        do_reset();
        set_cell(0, 5, 9); set_cell(1, 5, 9); set_cell(2, 20, 3); set_cell(3, 5, 10);
        model_commit(3'd2, exp);
        send_commit(3'd2, done_cyc, busy_low, b_after, d_after);
        read_cell(20, 3);
        n_checks++; if (Probe_Occupied !== 1'b1 || Draw_Color !== 3'd0) begin n_fail++; $display("[TB] FAIL probe_row20: occ %0b color %0d, expected occ 1 color 0", Probe_Occupied, Draw_Color); end
        read_cell(5, 10);
        n_checks++; if (Probe_Occupied !== 1'b1 || Draw_Color !== 3'd0) begin n_fail++; $display("[TB] FAIL probe_col10: occ %0b color %0d, expected occ 1 color 0", Probe_Occupied, Draw_Color); end
        read_cell(31, 15);
        n_checks++; if (Probe_Occupied !== 1'b1 || Draw_Color !== 3'd0) begin n_fail++; $display("[TB] FAIL probe_far: occ %0b color %0d, expected occ 1 color 0", Probe_Occupied, Draw_Color); end
        read_board(diffs, first);
        n_checks++; if (diffs !== 0) begin n_fail++; $display("[TB] FAIL probe_board: %0d bad cells, first %s", diffs, first); end
    endtask

    task automatic test_reset_mid_write();
        int diffs; string first;
        do_reset();
        set_cell(0, 19, 0); set_cell(1, 19, 1); set_cell(2, 19, 2); set_cell(3, 19, 3);
        @(negedge Clk);
        En_New_Static = 1'b1; New_Static_Row = pc_rows; New_Static_Column = pc_cols; New_Static_Color = 3'd4;
        @(negedge Clk);
        En_New_Static = 1'b0;
        @(negedge Clk);
        read_cell(19, 0);
        n_checks++; if (Draw_Color !== 3'd4) begin n_fail++; $display("[TB] FAIL midwrite_visible: got %0d expected 4", Draw_Color); end
        @(negedge Clk);
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midwrite_busy: got %0b expected 1", Busy); end
        Reset = 1'b1;
        @(negedge Clk);
        n_checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("[TB] FAIL midwrite_reset_flags: busy %0b done %0b, expected 0 0", Busy, Done); end
        Reset = 1'b0;
        model_reset();
        read_board(diffs, first);
        n_checks++; if (diffs !== 0) begin n_fail++; $display("[TB] FAIL midwrite_board: %0d bad cells, first %s", diffs, first); end
    endtask

    task automatic test_random();
        int exp, done_cyc, busy_low, diffs, mode, r, c; logic b_after, d_after; string first;
        logic [2:0] color;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            color = 3'($urandom_range(1, 7));
            mode  = int'($urandom_range(0, 9));
            if (mode < 7) begin
                r = int'($urandom_range(14, 19));
                c = int'($urandom_range(0, 9));
                for (int i = 0; i < 4; i++) set_cell(i, r, c + i);
            end else if (mode < 9) begin
                r = int'($urandom_range(15, 22));
                c = int'($urandom_range(0, 11));
                for (int i = 0; i < 4; i++) set_cell(i, r + i - 3, c);
            end else begin
                for (int i = 0; i < 4; i++)
                    set_cell(i, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
            end
            model_commit(color, exp);
            send_commit(color, done_cyc, busy_low, b_after, d_after);
            n_checks++; if (done_cyc !== exp) begin n_fail++; $display("[TB] FAIL rand%0d_cycle: got %0d expected %0d", it, done_cyc, exp); end
            n_checks++; if (busy_low !== 0 || b_after !== 1'b0) begin n_fail++; $display("[TB] FAIL rand%0d_busy: low %0d after %0b, expected 0 0", it, busy_low, b_after); end
            n_checks++; if (Lines_Cleared !== 3'(m_lines)) begin n_fail++; $display("[TB] FAIL rand%0d_lines: got %0d expected %0d", it, Lines_Cleared, m_lines); end
            n_checks++; if (Lines_Total !== 10'(m_total)) begin n_fail++; $display("[TB] FAIL rand%0d_total: got %0d expected %0d", it, Lines_Total, m_total); end
            n_checks++; if (Top_Out !== m_top) begin n_fail++; $display("[TB] FAIL rand%0d_top_out: got %0b expected %0b", it, Top_Out, m_top); end
            read_board(diffs, first);
            n_checks++; if (diffs !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_board: %0d bad cells, first %s", it, diffs, first); end
        end
    endtask

    initial begin
        Reset = 1'b1;
        En_New_Static = 1'b0;
        New_Static_Row = '0;
        New_Static_Column = '0;
        New_Static_Color = 3'd0;
        Draw_Row = '0; Draw_Column = '0;
        Probe_Row = '0; Probe_Column = '0;
        pc_rows = '0; pc_cols = '0;
        model_reset();
        test_reset();
        test_basic_commit();
        test_single_clear();
        test_quad_clear();
        test_ignored_requests();
        test_top_out();
        test_probe_bounds();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
